multi_key_debouncer: RTL and testbench

MULTI_KEY_DEBOUNCER -- requirements
Module: multi_key_debouncer

---
 rtl/multi_key_debouncer_pkg.sv | 22 ++
 rtl/key_debounce_channel.sv | 130 +++++++++++++
 rtl/multi_key_debouncer.sv | 70 +++++++
 tb/tb_multi_key_debouncer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_key_debouncer_pkg.sv
// Shared constants and helpers for the multi-key debouncer.
// Optional feature macro: MULTI_KEY_DEBOUNCER_REPEAT_EN (auto-repeat of key_pressed).
package multi_key_debouncer_pkg;

   localparam int DEFAULT_N_KEYS          = 4;
   localparam int DEFAULT_DEPTH           = 8;
   localparam int DEFAULT_STROBE_WIDTH    = 16;
   localparam int DEFAULT_ACTIVE_LOW_KEYS = 1;
   localparam int DEFAULT_REPEAT_DELAY    = 64;
   localparam int DEFAULT_REPEAT_PERIOD   = 16;

   // Number of bits needed to hold values 0..value-1 (value >= 2 in practice).
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One debounce channel: 2-flop synchroniser, strobe-driven integrating counter,
// debounced state and one-clock press/release pulses.
// With MULTI_KEY_DEBOUNCER_REPEAT_EN defined, a held key re-pulses key_pressed.
module key_debounce_channel
   import multi_key_debouncer_pkg::*;
#(
   parameter int DEPTH           = DEFAULT_DEPTH,
   parameter int ACTIVE_LOW_KEYS = DEFAULT_ACTIVE_LOW_KEYS,
   parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
)(
   input  logic clk,
   input  logic reset,
   input  logic strobe,
   input  logic key_raw,
   output logic key_state,
   output logic key_state_next,
   output logic key_pressed,
   output logic key_released
);

   localparam int CW = clog2(DEPTH + 1);

   logic          sync1_reg;
   logic          sync2_reg;
   logic          sample;
   logic [CW-1:0] cnt_reg;
   logic [CW-1:0] cnt_next;
   logic          state_reg;
   logic          state_next;
   logic          flip;
   logic          repeat_fire;
   logic          pressed_reg;
   logic          pressed_next;
   logic          released_reg;
   logic          released_next;

   // Sample is "1 = pressed" regardless of the key's electrical polarity.
   assign sample = (ACTIVE_LOW_KEYS != 0) ? ~sync2_reg : sync2_reg;

   // Count consecutive differing strobes; flip state on the DEPTH-th one.
   always_comb begin
      cnt_next   = cnt_reg;
      state_next = state_reg;
      flip       = 1'b0;
      if (strobe) begin
         if (sample != state_reg) begin
            if (cnt_reg == CW'(DEPTH - 1)) begin
               flip       = 1'b1;
               cnt_next   = '0;
               state_next = ~state_reg;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end else begin
            cnt_next = '0;
         end
      end
      pressed_next  = (flip & state_next) | repeat_fire;
      released_next = flip & ~state_next;
   end

   // Synchroniser, counter, debounced state and pulse registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_reg    <= 1'b0;
         sync2_reg    <= 1'b0;
         cnt_reg      <= '0;
         state_reg    <= 1'b0;
         pressed_reg  <= 1'b0;
         released_reg <= 1'b0;
      end else begin
         sync1_reg    <= key_raw;
         sync2_reg    <= sync1_reg;
         cnt_reg      <= cnt_next;
         state_reg    <= state_next;
         pressed_reg  <= pressed_next;
         released_reg <= released_next;
      end
   end

`ifdef MULTI_KEY_DEBOUNCER_REPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW      = clog2(RPT_MAX + 1);

   logic [RW-1:0] rpt_cnt_reg;
   logic [RW-1:0] rpt_cnt_next;
   logic          rpt_first_reg;
   logic          rpt_first_next;

   // Repeat timer: runs only while debounced-pressed; first interval is the delay.
   always_comb begin
      rpt_cnt_next   = rpt_cnt_reg;
      rpt_first_next = rpt_first_reg;
      repeat_fire    = 1'b0;
      if (!state_reg) begin
         rpt_cnt_next   = '0;
         rpt_first_next = 1'b1;
      end else if (strobe && !flip) begin
         if ((int'(rpt_cnt_reg) + 1) == (rpt_first_reg ? REPEAT_DELAY : REPEAT_PERIOD)) begin
            repeat_fire    = 1'b1;
            rpt_cnt_next   = '0;
            rpt_first_next = 1'b0;
         end else begin
            rpt_cnt_next = rpt_cnt_reg + 1'b1;
         end
      end
   end

   // Repeat timer registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rpt_cnt_reg   <= '0;
         rpt_first_reg <= 1'b1;
      end else begin
         rpt_cnt_reg   <= rpt_cnt_next;
         rpt_first_reg <= rpt_first_next;
      end
   end
`else
   // Repeat disabled; the parameters stay so both builds share one interface.
   assign repeat_fire = 1'b0 & (REPEAT_DELAY == REPEAT_PERIOD);
`endif

   assign key_state      = state_reg;
   assign key_state_next = state_next;
   assign key_pressed    = pressed_reg;
   assign key_released   = released_reg;

endmodule

// File: rtl/multi_key_debouncer.sv
// Multi-key debouncer top: shared sample-strobe counter and N_KEYS channels.
// Optional feature macro: MULTI_KEY_DEBOUNCER_REPEAT_EN (auto-repeat of key_pressed).
module multi_key_debouncer
   import multi_key_debouncer_pkg::*;
#(
   parameter int N_KEYS          = DEFAULT_N_KEYS,
   parameter int DEPTH           = DEFAULT_DEPTH,
   parameter int STROBE_WIDTH    = DEFAULT_STROBE_WIDTH,
   parameter int ACTIVE_LOW_KEYS = DEFAULT_ACTIVE_LOW_KEYS,
   parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [N_KEYS-1:0] key_raw,
   output logic [N_KEYS-1:0] key_state,
   output logic [N_KEYS-1:0] key_pressed,
   output logic [N_KEYS-1:0] key_released,
   output logic              any_pressed
);

   logic [STROBE_WIDTH-1:0] strobe_cnt_reg;
   logic                    strobe;
   logic [N_KEYS-1:0]       state_next_bus;
   logic                    any_pressed_reg;

   // Free-running strobe counter; strobe marks its all-ones count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         strobe_cnt_reg <= '0;
      end else begin
         strobe_cnt_reg <= strobe_cnt_reg + 1'b1;
      end
   end

   assign strobe = &strobe_cnt_reg;

   // any_pressed registered from next-state so it changes with key_state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         any_pressed_reg <= 1'b0;
      end else begin
         any_pressed_reg <= |state_next_bus;
      end
   end

   assign any_pressed = any_pressed_reg;

   genvar gi;
   generate
      for (gi = 0; gi < N_KEYS; gi++) begin : g_chan
         key_debounce_channel #(
            .DEPTH           (DEPTH),
            .ACTIVE_LOW_KEYS (ACTIVE_LOW_KEYS),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
         ) u_chan (
            .clk            (clk),
            .reset          (reset),
            .strobe         (strobe),
            .key_raw        (key_raw[gi]),
            .key_state      (key_state[gi]),
            .key_state_next (state_next_bus[gi]),
            .key_pressed    (key_pressed[gi]),
            .key_released   (key_released[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_multi_key_debouncer.sv
// Testbench for multi_key_debouncer: directed scenarios plus a random run
// against a behavioural reference; expected pulse events go into a queue that
// a monitor drains whenever the DUT shows a press or release pulse.
// Build with MULTI_KEY_DEBOUNCER_REPEAT_EN defined to expect auto-repeat pulses.
module tb_multi_key_debouncer;

   localparam int NK   = 4;
   localparam int DEPTH = 3;
   localparam int SW   = 2;
   localparam int SPER = 1 << SW;
   localparam int RD   = 4;
   localparam int RP   = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [NK-1:0] key_raw = '0;
   logic [NK-1:0] key_state;
   logic [NK-1:0] key_pressed;
   logic [NK-1:0] key_released;
   logic          any_pressed;

   multi_key_debouncer #(
      .N_KEYS          (NK),
      .DEPTH           (DEPTH),
      .STROBE_WIDTH    (SW),
      .ACTIVE_LOW_KEYS (0),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .key_raw      (key_raw),
      .key_state    (key_state),
      .key_pressed  (key_pressed),
      .key_released (key_released),
      .any_pressed  (any_pressed)
   );

   always #5 clk = ~clk;

   // Clock edges since reset release; edge k is the k-th rising edge.
   int cyc;
   always @(posedge clk or negedge reset) begin
      if (!reset) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   typedef struct {
      int            cyc;
      logic [NK-1:0] p;
      logic [NK-1:0] r;
      logic [NK-1:0] s;
   } ev_t;

   ev_t q[$];

   int stim_checks = 0;
   int stim_errors = 0;
   int mon_checks  = 0;
   int mon_errors  = 0;

   bit count_en = 1'b0;
   int rises = 0;
   int falls = 0;
   int pcount = 0;
   int rcount = 0;

   // Reference model state for the random run.
   logic [NK-1:0] m_s1;
   logic [NK-1:0] m_s2;
   logic [NK-1:0] m_st;
   int            m_cnt[NK];
   int            m_rc[NK];
   bit            m_first[NK];

   // Monitor: pop and compare an expected event whenever a pulse appears.
   initial begin
      ev_t e;
      logic [NK-1:0] prev;
      prev = '0;
      forever begin
         @(negedge clk);
         #2;
         if (count_en) begin
            rises  += $countones(key_state & ~prev);
            falls  += $countones(~key_state & prev);
            pcount += $countones(key_pressed);
            rcount += $countones(key_released);
         end
         prev = key_state;
         if ((key_pressed | key_released) != '0) begin
            mon_checks++;
            if (q.size() == 0) begin
               mon_errors++;
               $display("FAIL unexpected_pulse cyc=%0d pressed=%b released=%b, required no pulse",
                        cyc, key_pressed, key_released);
            end else begin
               e = q.pop_front();
               if (cyc != e.cyc || key_pressed !== e.p || key_released !== e.r ||
                   key_state !== e.s || any_pressed !== (e.s != '0)) begin
                  mon_errors++;
                  $display("FAIL pulse_event cyc=%0d pressed=%b released=%b state=%b any=%b, required cyc=%0d pressed=%b released=%b state=%b any=%b",
                           cyc, key_pressed, key_released, key_state, any_pressed,
                           e.cyc, e.p, e.r, e.s, (e.s != '0));
               end else begin
                  $display("event cyc=%0d pressed=%b released=%b state=%b ok",
                           cyc, key_pressed, key_released, key_state);
               end
            end
         end
      end
   end

   // Global time limit so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached at cyc=%0d, required completion", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      stim_checks++;
      if (act !== exp) begin
         stim_errors++;
         $display("FAIL %s got=%0h required=%0h", name, act, exp);
      end else begin
         $display("check %s = %0h ok", name, act);
      end
   endtask

   task automatic wait_cyc(input int n);
      int guard;
      guard = 0;
      while (cyc < n && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      check("wait_cyc", cyc, n);
   endtask

   task automatic expect_ev(input int c, input logic [NK-1:0] p,
                            input logic [NK-1:0] r, input logic [NK-1:0] s);
      q.push_back('{c, p, r, s});
   endtask

   // Assert reset at a falling edge, check outputs clear at once, then release.
   task automatic do_reset(input logic [NK-1:0] k, input int low_clks);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("reset_key_state", key_state, 0);
      check("reset_key_pressed", key_pressed, 0);
      check("reset_key_released", key_released, 0);
      check("reset_any_pressed", any_pressed, 0);
      repeat (low_clks) @(negedge clk);
      key_raw = k;
      reset   = 1'b1;
   endtask

   // Behavioural model of rising edge k given the raw level present at that edge.
   task automatic model_step(input int k, input logic [NK-1:0] raw);
      logic [NK-1:0] samp;
      logic [NK-1:0] p;
      logic [NK-1:0] r;
      samp = m_s2;
      m_s2 = m_s1;
      m_s1 = raw;
      p = '0;
      r = '0;
      if (k >= SPER && (k % SPER) == 0) begin
         for (int i = 0; i < NK; i++) begin
            if (samp[i] == m_st[i]) begin
               m_cnt[i] = 0;
            end else begin
               m_cnt[i]++;
               if (m_cnt[i] == DEPTH) begin
                  m_cnt[i]   = 0;
                  m_st[i]    = samp[i];
                  m_rc[i]    = 0;
                  m_first[i] = 1'b1;
                  if (samp[i]) p[i] = 1'b1;
                  else         r[i] = 1'b1;
               end
            end
`ifdef MULTI_KEY_DEBOUNCER_REPEAT_EN
            if (m_st[i] && !p[i] && !r[i]) begin
               m_rc[i]++;
               if (m_rc[i] == (m_first[i] ? RD : RP)) begin
                  p[i]       = 1'b1;
                  m_rc[i]    = 0;
                  m_first[i] = 1'b0;
               end
            end
`endif
         end
      end
      if ((p | r) != '0) q.push_back('{k, p, r, m_st});
   endtask

   initial begin
      logic [NK-1:0] mask;

      // Single key press then release.
      do_reset(4'b0001, 2);
      expect_ev(12, 4'b0001, 4'b0000, 4'b0001);
      expect_ev(24, 4'b0000, 4'b0001, 4'b0000);
      wait_cyc(11);
      check("t1_state_before_depth", key_state, 4'b0000);
      wait_cyc(12);
      key_raw = 4'b0000;
      wait_cyc(13);
      check("t1_state_pressed", key_state, 4'b0001);
      check("t1_any_pressed", any_pressed, 1);
      check("t1_pulse_width", key_pressed, 4'b0000);
      wait_cyc(30);
      check("t1_state_released", key_state, 4'b0000);
      check("t1_queue_empty", q.size(), 0);

      // Glitch of two strobes must not register.
      do_reset(4'b0010, 2);
      wait_cyc(8);
      key_raw = 4'b0000;
      wait_cyc(40);
      check("t2_state", key_state, 4'b0000);
      check("t2_queue_empty", q.size(), 0);

      // Two keys together, pressed and released on the same clocks.
      do_reset(4'b1010, 2);
      expect_ev(12, 4'b1010, 4'b0000, 4'b1010);
      wait_cyc(13);
      check("t3_state", key_state, 4'b1010);
      check("t3_any_pressed", any_pressed, 1);
      wait_cyc(20);
      key_raw = 4'b0000;
      expect_ev(32, 4'b0000, 4'b1010, 4'b0000);
      wait_cyc(33);
      check("t3_any_released", any_pressed, 0);
      check("t3_queue_empty", q.size(), 0);

      // Reset mid-count with keys held; press reported DEPTH strobes after release.
      do_reset(4'b0001, 2);
      expect_ev(12, 4'b0001, 4'b0000, 4'b0001);
      wait_cyc(12);
      key_raw = 4'b0011;
      wait_cyc(20);
      check("t4_state_before_reset", key_state, 4'b0001);
      do_reset(4'b0011, 1);
      expect_ev(12, 4'b0011, 4'b0000, 4'b0011);
      wait_cyc(11);
      check("t4_state_after_reset", key_state, 4'b0000);
      wait_cyc(13);
      check("t4_state_pressed", key_state, 4'b0011);
      check("t4_queue_empty", q.size(), 0);

      // Long hold: repeats only when the repeat feature is built in.
      do_reset(4'b0001, 2);
      expect_ev(12, 4'b0001, 4'b0000, 4'b0001);
`ifdef MULTI_KEY_DEBOUNCER_REPEAT_EN
      for (int c = 28; c <= 68; c += 8 * RP / 2) begin
         if (c == 28 || c >= 36) expect_ev(c, 4'b0001, 4'b0000, 4'b0001);
      end
`endif
      expect_ev(72, 4'b0000, 4'b0001, 4'b0000);
      wait_cyc(60);
      key_raw = 4'b0000;
      wait_cyc(80);
      check("t5_state", key_state, 4'b0000);
      check("t5_queue_empty", q.size(), 0);

      // Random run against the reference model.
      do_reset(4'b0000, 2);
      m_s1 = '0;
      m_s2 = '0;
      m_st = '0;
      for (int i = 0; i < NK; i++) begin
         m_cnt[i]   = 0;
         m_rc[i]    = 0;
         m_first[i] = 1'b1;
      end
      count_en = 1'b1;
      for (int n = 0; n < 4000; n++) begin
         @(negedge clk);
         model_step(cyc, key_raw);
         for (int i = 0; i < NK; i++) mask[i] = ($urandom_range(7) == 0);
         key_raw = key_raw ^ mask;
      end
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         model_step(cyc, key_raw);
         key_raw = 4'b0000;
      end
      @(negedge clk);
      model_step(cyc, key_raw);
      #3;
      count_en = 1'b0;
      check("rand_queue_empty", q.size(), 0);
      check("rand_released_vs_falls", rcount, falls);
`ifndef MULTI_KEY_DEBOUNCER_REPEAT_EN
      check("rand_pressed_vs_rises", pcount, rises);
`endif
      check("rand_activity_seen", (rises > 0), 1);

      $display("Simulation finished: %0d checks, %0d errors",
               stim_checks + mon_checks, stim_errors + mon_errors);
      $finish;
   end

endmodule
